// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor
// Passive observer of a two-road traffic-light controller. The six lamp drives
// are sampled every clock and tracked against the legal phase ring
// G1 -> Y1 -> AR1 -> G2 -> Y2 -> AR2 -> G1 (the all-red phases may be skipped).
// Green and yellow dwell times are checked. A violation raises a one-cycle
// ERR_VALID, records its code and sets a sticky ERR flag. The tracker then
// falls back to INIT and resynchronises on the next clean green.
// Completed full signal cycles are counted in CYCLE_CNT.

module traffic_light_monitor #(
   parameter int MIN_GRN = 4,
   parameter int MIN_YLW = 2,
   parameter int MAX_YLW = 6
) (
   input  logic       CK,
   input  logic       CLR,
   input  logic       GRN1,
   input  logic       YLW1,
   input  logic       RED1,
   input  logic       GRN2,
   input  logic       YLW2,
   input  logic       RED2,
   input  logic       ERR_CLR,
   output logic       ERR,
   output logic       ERR_VALID,
   output logic [2:0] ERR_CODE,
   output logic [2:0] PHASE,
   output logic [7:0] CYCLE_CNT
);

   // Monitor phases; the encoding is visible on PHASE.
   typedef enum logic [2:0] {
      S_INIT = 3'd0,
      S_G1   = 3'd1,
      S_Y1   = 3'd2,
      S_AR1  = 3'd3,
      S_G2   = 3'd4,
      S_Y2   = 3'd5,
      S_AR2  = 3'd6
   } state_t;

   // What the lamps show on one sample, independent of history.
   typedef enum logic [2:0] {
      L_G1  = 3'd0,
      L_Y1  = 3'd1,
      L_AR  = 3'd2,
      L_G2  = 3'd3,
      L_Y2  = 3'd4,
      L_BAD = 3'd5
   } look_t;

   // Violation codes. A lower value means a higher priority.
   localparam logic [2:0] C_NONE    = 3'd0;
   localparam logic [2:0] C_ONEHOT  = 3'd1;
   localparam logic [2:0] C_BOTH    = 3'd2;
   localparam logic [2:0] C_ILLEGAL = 3'd3;
   localparam logic [2:0] C_GMIN    = 3'd4;
   localparam logic [2:0] C_YMIN    = 3'd5;
   localparam logic [2:0] C_YMAX    = 3'd6;

   localparam logic [7:0] MIN_GRN_C = 8'(MIN_GRN);
   localparam logic [7:0] MIN_YLW_C = 8'(MIN_YLW);
   localparam logic [7:0] MAX_YLW_C = 8'(MAX_YLW);
   localparam logic [7:0] SAT_C     = 8'd255;

   // Exactly one lamp lit on a road head.
   function automatic logic is_onehot3(input logic [2:0] v);
      return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
   endfunction

   // A road is allowed to move traffic (green or yellow lit).
   function automatic logic road_go(input logic [2:0] v);
      return v[2] | v[1];
   endfunction

   state_t     state_r;
   logic [7:0] dwell_r;
   logic       first_grn_r;
   logic       err_r;
   logic       err_valid_r;
   logic [2:0] err_code_r;
   logic [7:0] cycle_cnt_r;

   logic [2:0] road1_s;
   logic [2:0] road2_s;
   logic       onehot_err_s;
   logic       both_go_err_s;
   look_t      look_s;
   state_t     next_state_s;
   logic [2:0] fsm_code_s;
   logic [2:0] viol_code_s;
   logic       cycle_inc_s;

   assign road1_s       = {GRN1, YLW1, RED1};
   assign road2_s       = {GRN2, YLW2, RED2};
   assign onehot_err_s  = !is_onehot3(road1_s) || !is_onehot3(road2_s);
   assign both_go_err_s = road_go(road1_s) && road_go(road2_s);

   // Decode the six lamps into one observed pattern.
   always_comb begin
      look_s = L_BAD;
      case ({road1_s, road2_s})
         6'b100_001: look_s = L_G1;
         6'b010_001: look_s = L_Y1;
         6'b001_001: look_s = L_AR;
         6'b001_100: look_s = L_G2;
         6'b001_010: look_s = L_Y2;
         default:    look_s = L_BAD;
      endcase
   end

   // Transition legality, dwell limits and next phase from the current phase.
   always_comb begin
      next_state_s = state_r;
      fsm_code_s   = C_NONE;
      cycle_inc_s  = 1'b0;
      case (state_r)
         S_INIT: begin
            // Only a clean green locks the tracker on; anything else waits.
            if (look_s == L_G1) begin
               next_state_s = S_G1;
            end else if (look_s == L_G2) begin
               next_state_s = S_G2;
            end else begin
               next_state_s = S_INIT;
            end
         end
         S_G1: begin
            if (look_s == L_G1) begin
               next_state_s = S_G1;
            end else if (look_s == L_Y1) begin
               next_state_s = S_Y1;
               // The first green seen after INIT has an unknown start, so its length is not judged.
               if (!first_grn_r && (dwell_r < MIN_GRN_C)) begin
                  fsm_code_s = C_GMIN;
               end else begin
                  fsm_code_s = C_NONE;
               end
            end else begin
               fsm_code_s = C_ILLEGAL;
            end
         end
         S_Y1: begin
            if (look_s == L_Y1) begin
               next_state_s = S_Y1;
               if (dwell_r >= MAX_YLW_C) begin
                  fsm_code_s = C_YMAX;
               end else begin
                  fsm_code_s = C_NONE;
               end
            end else if ((look_s == L_AR) || (look_s == L_G2)) begin
               next_state_s = (look_s == L_AR) ? S_AR1 : S_G2;
               if (dwell_r < MIN_YLW_C) begin
                  fsm_code_s = C_YMIN;
               end else begin
                  fsm_code_s = C_NONE;
               end
            end else begin
               fsm_code_s = C_ILLEGAL;
            end
         end
         S_AR1: begin
            if (look_s == L_AR) begin
               next_state_s = S_AR1;
            end else if (look_s == L_G2) begin
               next_state_s = S_G2;
            end else begin
               fsm_code_s = C_ILLEGAL;
            end
         end
         S_G2: begin
            if (look_s == L_G2) begin
               next_state_s = S_G2;
            end else if (look_s == L_Y2) begin
               next_state_s = S_Y2;
               if (!first_grn_r && (dwell_r < MIN_GRN_C)) begin
                  fsm_code_s = C_GMIN;
               end else begin
                  fsm_code_s = C_NONE;
               end
            end else begin
               fsm_code_s = C_ILLEGAL;
            end
         end
         S_Y2: begin
            if (look_s == L_Y2) begin
               next_state_s = S_Y2;
               if (dwell_r >= MAX_YLW_C) begin
                  fsm_code_s = C_YMAX;
               end else begin
                  fsm_code_s = C_NONE;
               end
            end else if ((look_s == L_AR) || (look_s == L_G1)) begin
               next_state_s = (look_s == L_AR) ? S_AR2 : S_G1;
               cycle_inc_s  = (look_s == L_G1);
               if (dwell_r < MIN_YLW_C) begin
                  fsm_code_s = C_YMIN;
               end else begin
                  fsm_code_s = C_NONE;
               end
            end else begin
               fsm_code_s = C_ILLEGAL;
            end
         end
         S_AR2: begin
            if (look_s == L_AR) begin
               next_state_s = S_AR2;
            end else if (look_s == L_G1) begin
               next_state_s = S_G1;
               cycle_inc_s  = 1'b1;
            end else begin
               fsm_code_s = C_ILLEGAL;
            end
         end
         default: begin
            // An unused encoding can only come from an upset. Report it and restart.
            next_state_s = S_INIT;
            fsm_code_s   = C_ILLEGAL;
         end
      endcase
   end

   // Resolve simultaneous failures to the lowest code. Lamp-sanity checks apply in every phase.
   always_comb begin
      if (onehot_err_s) begin
         viol_code_s = C_ONEHOT;
      end else if (both_go_err_s) begin
         viol_code_s = C_BOTH;
      end else begin
         viol_code_s = fsm_code_s;
      end
   end

   // Phase tracker, dwell counter, error reporting and cycle counter.
   always_ff @(posedge CK or negedge CLR) begin
      if (!CLR) begin
         state_r     <= S_INIT;
         dwell_r     <= 8'd0;
         first_grn_r <= 1'b0;
         err_r       <= 1'b0;
         err_valid_r <= 1'b0;
         err_code_r  <= 3'd0;
         cycle_cnt_r <= 8'd0;
      end else if (viol_code_s != C_NONE) begin
         // A violation wins over ERR_CLR and leaves CYCLE_CNT unchanged.
         state_r     <= S_INIT;
         dwell_r     <= 8'd0;
         first_grn_r <= 1'b0;
         err_r       <= 1'b1;
         err_valid_r <= 1'b1;
         err_code_r  <= viol_code_s;
      end else begin
         err_valid_r <= 1'b0;
         if (next_state_s != state_r) begin
            state_r     <= next_state_s;
            dwell_r     <= 8'd1;
            first_grn_r <= (state_r == S_INIT);
         end else if (state_r == S_INIT) begin
            dwell_r <= 8'd0;
         end else if (dwell_r != SAT_C) begin
            dwell_r <= dwell_r + 8'd1;
         end
         if (cycle_inc_s && (cycle_cnt_r != SAT_C)) begin
            cycle_cnt_r <= cycle_cnt_r + 8'd1;
         end
         if (ERR_CLR) begin
            err_r      <= 1'b0;
            err_code_r <= 3'd0;
         end
      end
   end

   assign ERR       = err_r;
   assign ERR_VALID = err_valid_r;
   assign ERR_CODE  = err_code_r;
   assign PHASE     = state_r;
   assign CYCLE_CNT = cycle_cnt_r;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Testbench for traffic_light_monitor. Every driven sample is run through a
// rule-level reference model. The model's predicted outputs go into a queue.
// A monitor pops one entry after each clock edge and compares it with the DUT.

module tb_traffic_light_monitor;

   localparam int MIN_GRN = 4;
   localparam int MIN_YLW = 2;
   localparam int MAX_YLW = 6;

   // Lamp patterns as {GRN1,YLW1,RED1,GRN2,YLW2,RED2}.
   localparam logic [5:0] P_G1 = 6'b100_001;
   localparam logic [5:0] P_Y1 = 6'b010_001;
   localparam logic [5:0] P_AR = 6'b001_001;
   localparam logic [5:0] P_G2 = 6'b001_100;
   localparam logic [5:0] P_Y2 = 6'b001_010;

   logic       CK = 1'b0;
   logic       CLR = 1'b0;
   logic       GRN1, YLW1, RED1, GRN2, YLW2, RED2;
   logic       ERR_CLR;
   logic       ERR, ERR_VALID;
   logic [2:0] ERR_CODE, PHASE;
   logic [7:0] CYCLE_CNT;

   int n_vec = 0;
   int n_err = 0;

   typedef struct packed {
      logic       v;
      logic [2:0] code;
      logic       err;
      logic [2:0] phase;
      logic [7:0] cnt;
   } obs_t;

   obs_t exp_q[$];

   // Reference model state (phase numbers 0..6 as the spec names them).
   int m_state, m_dwell, m_code, m_cnt;
   bit m_skip, m_err;

   // Legal successors of each phase (-1 = none).
   int succ_a [7] = '{-1, 2, 3, 4, 5, 6, 1};
   int succ_b [7] = '{-1, -1, 4, -1, -1, 1, -1};

   traffic_light_monitor #(.MIN_GRN(MIN_GRN), .MIN_YLW(MIN_YLW), .MAX_YLW(MAX_YLW)) dut (
      .CK(CK), .CLR(CLR),
      .GRN1(GRN1), .YLW1(YLW1), .RED1(RED1),
      .GRN2(GRN2), .YLW2(YLW2), .RED2(RED2),
      .ERR_CLR(ERR_CLR), .ERR(ERR), .ERR_VALID(ERR_VALID),
      .ERR_CODE(ERR_CODE), .PHASE(PHASE), .CYCLE_CNT(CYCLE_CNT)
   );

   always #5 CK = ~CK;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   // Which phase a sample looks like, given where we are (all-red is AR1 or AR2 by context).
   function automatic int look(input logic [5:0] s, input int cur);
      case (s)
         P_G1: return 1;
         P_Y1: return 2;
         P_G2: return 4;
         P_Y2: return 5;
         P_AR: return (cur == 2 || cur == 3) ? 3 : ((cur == 5 || cur == 6) ? 6 : 0);
         default: return -1;
      endcase
   endfunction

   task automatic model_reset();
      m_state = 0; m_dwell = 0; m_code = 0; m_cnt = 0; m_skip = 0; m_err = 0;
   endtask

   task automatic model_step(input logic [5:0] s, input logic clr);
      int   c = 7;
      int   cur;
      int   t;
      obs_t e;
      cur = m_state;
      if ($countones(s[5:3]) != 1 || $countones(s[2:0]) != 1) c = 1;
      else if ((s[5] | s[4]) && (s[2] | s[1])) c = 2;
      t = look(s, cur);
      if (c == 7 && cur != 0) begin
         if (t == cur) begin
            if ((cur == 2 || cur == 5) && m_dwell + 1 > MAX_YLW) c = 6;
         end else if (t != succ_a[cur] && t != succ_b[cur]) c = 3;
         else if ((cur == 1 || cur == 4) && !m_skip && m_dwell < MIN_GRN) c = 4;
         else if ((cur == 2 || cur == 5) && m_dwell < MIN_YLW) c = 5;
      end
      if (c != 7) begin
         m_state = 0; m_dwell = 0; m_skip = 0; m_err = 1; m_code = c;
      end else begin
         if (cur == 0) begin
            if (t == 1 || t == 4) begin
               m_state = t; m_dwell = 1; m_skip = 1;
            end
         end else if (t == cur) begin
            m_dwell = (m_dwell < 255) ? m_dwell + 1 : 255;
         end else begin
            if (t == 1 && m_cnt < 255) m_cnt = m_cnt + 1;
            m_state = t; m_dwell = 1; m_skip = 0;
         end
         if (clr) begin
            m_err = 0; m_code = 0;
         end
      end
      e.v     = (c != 7);
      e.code  = 3'(m_code);
      e.err   = m_err;
      e.phase = 3'(m_state);
      e.cnt   = 8'(m_cnt);
      exp_q.push_back(e);
   endtask

   task automatic apply(input logic [5:0] s, input logic clr);
      @(negedge CK);
      {GRN1, YLW1, RED1, GRN2, YLW2, RED2} = s;
      ERR_CLR = clr;
      model_step(s, clr);
   endtask

   task automatic chk(input string nm, input int act, input int req);
      n_vec++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d", nm, act, req);
      end
   endtask

   task automatic settle();
      @(posedge CK);
      #2;
   endtask

   // Assert reset between edges, check outputs clear at once, then release with idle lamps.
   task automatic do_reset(input string tag);
      @(negedge CK);
      CLR = 1'b0;
      #1;
      chk({tag, "_err"}, ERR, 0);
      chk({tag, "_valid"}, ERR_VALID, 0);
      chk({tag, "_code"}, ERR_CODE, 0);
      chk({tag, "_phase"}, PHASE, 0);
      chk({tag, "_cnt"}, CYCLE_CNT, 0);
      model_reset();
      repeat (2) @(negedge CK);
      {GRN1, YLW1, RED1, GRN2, YLW2, RED2} = P_AR;
      ERR_CLR = 1'b0;
      CLR = 1'b1;
      model_step(P_AR, 1'b0);
   endtask

   task automatic hold(input logic [5:0] s, input int n);
      for (int i = 0; i < n; i++) apply(s, 1'b0);
   endtask

   // Scoreboard monitor: one expected entry per sampled edge.
   always @(posedge CK) begin
      obs_t e;
      obs_t a;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {ERR_VALID, ERR_CODE, ERR, PHASE, CYCLE_CNT};
         n_vec++;
         if (a !== e) begin
            n_err++;
            $display("FAIL scoreboard @%0t: got v=%0b code=%0d err=%0b phase=%0d cnt=%0d, expected v=%0b code=%0d err=%0b phase=%0d cnt=%0d",
                     $time, a.v, a.code, a.err, a.phase, a.cnt, e.v, e.code, e.err, e.phase, e.cnt);
         end
      end
   end

   initial begin
      logic [5:0] ring [6];
      int         seq_idx;
      int         hold_n;
      int         r;
      logic [5:0] s;
      logic       clr;

      {GRN1, YLW1, RED1, GRN2, YLW2, RED2} = P_AR;
      ERR_CLR = 1'b0;
      model_reset();
      repeat (2) @(negedge CK);
      do_reset("rst0");

      // Full legal cycle with minimum dwells.
      hold(P_G1, 4); hold(P_Y1, 2); hold(P_AR, 1);
      hold(P_G2, 4); hold(P_Y2, 2); hold(P_AR, 1);
      apply(P_G1, 1'b0);
      settle();
      chk("legal_cnt", CYCLE_CNT, 1);
      chk("legal_phase", PHASE, 1);
      chk("legal_err", ERR, 0);

      // Both greens while in G1.
      apply(6'b100_100, 1'b0);
      settle();
      chk("bothgrn_valid", ERR_VALID, 1);
      chk("bothgrn_code", ERR_CODE, 2);
      chk("bothgrn_err", ERR, 1);
      chk("bothgrn_phase", PHASE, 0);
      apply(P_AR, 1'b0);
      settle();
      chk("bothgrn_pulse", ERR_VALID, 0);
      apply(P_AR, 1'b1);
      settle();
      chk("errclr_err", ERR, 0);
      chk("errclr_code", ERR_CODE, 0);

      // Short green entered from AR2 versus a short first green.
      hold(P_G2, 4); hold(P_Y2, 2); hold(P_AR, 1);
      hold(P_G1, 3); apply(P_Y1, 1'b0);
      settle();
      chk("gmin_code", ERR_CODE, 4);
      chk("gmin_valid", ERR_VALID, 1);
      hold(P_G1, 1); apply(P_Y1, 1'b0);
      settle();
      chk("gmin_skip_valid", ERR_VALID, 0);
      chk("gmin_skip_phase", PHASE, 2);

      // Yellow held too long: six samples are fine, the seventh is not.
      hold(P_Y1, 5);
      settle();
      chk("ymax_6_valid", ERR_VALID, 0);
      apply(P_Y1, 1'b0);
      settle();
      chk("ymax_7_valid", ERR_VALID, 1);
      chk("ymax_7_code", ERR_CODE, 6);
      apply(6'b110_100, 1'b0);
      settle();
      chk("prio_code", ERR_CODE, 1);

      // Five counted cycles, a violation, then reset between edges.
      do_reset("rst1");
      hold(P_G1, 4);
      for (int k = 0; k < 5; k++) begin
         hold(P_Y1, 2);
         if (k != 2) hold(P_AR, 1);
         hold(P_G2, 4); hold(P_Y2, 2);
         if (k != 3) hold(P_AR, 1);
         hold(P_G1, 4);
      end
      apply(6'b000_001, 1'b0);
      settle();
      chk("pre_rst_err", ERR, 1);
      chk("pre_rst_cnt", CYCLE_CNT, 5);
      do_reset("rst2");

      // ERR_CLR loses to a violation on the same sample.
      apply(6'b100_100, 1'b0);
      apply(6'b110_001, 1'b1);
      settle();
      chk("clr_vs_viol_err", ERR, 1);
      chk("clr_vs_viol_code", ERR_CODE, 1);

      // Randomised walk around the ring with random dwells, skips, garbage and clears.
      ring[0] = P_G1; ring[1] = P_Y1; ring[2] = P_AR;
      ring[3] = P_G2; ring[4] = P_Y2; ring[5] = P_AR;
      seq_idx = 5;
      hold_n = 0;
      for (int i = 0; i < 3000; i++) begin
         if (hold_n == 0) begin
            r = $urandom_range(0, 99);
            if (r < 8) seq_idx = (seq_idx + 2) % 6;
            else seq_idx = (seq_idx + 1) % 6;
            hold_n = $urandom_range(1, 7);
         end
         s = ring[seq_idx];
         hold_n = hold_n - 1;
         if ($urandom_range(0, 99) < 3) s = 6'($urandom);
         clr = ($urandom_range(0, 99) < 5);
         apply(s, clr);
      end

      repeat (3) @(negedge CK);
      chk("queue_drain", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
